// File: rtl/tx_cordic_upconverter.sv
// Digital upconverter: a zero-order-held I/Q sample is rotated by an NCO phase
// through a pipelined CORDIC, and the real part is rounded and saturated for the DAC.
module tx_cordic_upconverter #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 12,
    parameter int STG       = 16
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic signed [31:0]          frequency,
    input  logic                        tx_enable,
    input  logic                        in_valid,
    input  logic signed [IN_WIDTH-1:0]  in_I,
    input  logic signed [IN_WIDTH-1:0]  in_Q,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_valid
);

    localparam int WR = IN_WIDTH + 2;
    localparam int WZ = STG + 2;
    localparam int S  = IN_WIDTH - OUT_WIDTH + 1;
    localparam int CW = $clog2(STG + 3);

    localparam logic signed [WR-1:0] RND  = WR'(1) << (S - 1);
    localparam logic signed [WR-1:0] OMAX = WR'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [WR-1:0] OMIN = WR'(-(1 << (OUT_WIDTH - 1)));

    // atan(2^-i) in Z units (full circle = 2^(WZ+1)), evaluated at elaboration by power series
    function automatic logic signed [WZ-1:0] atan_const(input int i);
        real x, pw, sum, scale;
        x     = 1.0;
        sum   = 0.0;
        scale = 1.0;
        for (int k = 0; k < i; k++) x = x / 2.0;
        if (i == 0) begin
            sum = 3.14159265358979323846 / 4.0;
        end else begin
            pw = x;
            for (int k = 0; k < 40; k++) begin
                sum = ((k % 2) == 1) ? sum - pw / real'(2 * k + 1) : sum + pw / real'(2 * k + 1);
                pw  = pw * x * x;
            end
        end
        for (int k = 0; k < WZ + 1; k++) scale = scale * 2.0;
        return WZ'($rtoi(sum * scale / (2.0 * 3.14159265358979323846) + 0.5));
    endfunction

    logic        [31:0]         phase;
    logic signed [IN_WIDTH-1:0] hold_i, hold_q;
    logic        [1:0]          quad;
    logic signed [WR-1:0]       ext_i, ext_q, x_load, y_load;
    logic signed [WZ-1:0]       z_load;
    logic signed [WR-1:0]       xs [STG+1];
    logic signed [WR-1:0]       ys [STG+1];
    logic signed [WZ-1:0]       zs [STG+1];
    logic signed [WR-1:0]       rnd_x;
    logic        [CW-1:0]       fill_cnt;

    // Rounding the quadrant with phase[29] keeps the residual angle inside [-pi/4, pi/4)
    always_comb begin
        quad   = phase[31:30] + {1'b0, phase[29]};
        ext_i  = {{(WR-IN_WIDTH){hold_i[IN_WIDTH-1]}}, hold_i};
        ext_q  = {{(WR-IN_WIDTH){hold_q[IN_WIDTH-1]}}, hold_q};
        z_load = {phase[29], phase[29:31-WZ]};
        x_load = ext_i;
        y_load = ext_q;
        case (quad)
            2'd0: begin x_load = ext_i;  y_load = ext_q;  end
            2'd1: begin x_load = -ext_q; y_load = ext_i;  end
            2'd2: begin x_load = -ext_i; y_load = -ext_q; end
            default: begin x_load = ext_q; y_load = -ext_i; end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase  <= '0;
            hold_i <= '0;
            hold_q <= '0;
            xs[0]  <= '0;
            ys[0]  <= '0;
            zs[0]  <= '0;
        end else begin
            phase <= phase + frequency;
            if (!tx_enable) begin
                hold_i <= '0;
                hold_q <= '0;
            end else if (in_valid) begin
                hold_i <= in_I;
                hold_q <= in_Q;
            end
            xs[0] <= x_load;
            ys[0] <= y_load;
            zs[0] <= z_load;
        end
    end

    for (genvar i = 0; i < STG; i++) begin : g_iter
        localparam logic signed [WZ-1:0] ATAN = atan_const(i);
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                xs[i+1] <= '0;
                ys[i+1] <= '0;
                zs[i+1] <= '0;
            end else if (!zs[i][WZ-1]) begin
                xs[i+1] <= xs[i] - (ys[i] >>> i);
                ys[i+1] <= ys[i] + (xs[i] >>> i);
                zs[i+1] <= zs[i] - ATAN;
            end else begin
                xs[i+1] <= xs[i] + (ys[i] >>> i);
                ys[i+1] <= ys[i] - (xs[i] >>> i);
                zs[i+1] <= zs[i] + ATAN;
            end
        end
    end

    always_comb rnd_x = (xs[STG] + RND) >>> S;

    // Fill counter runs from the first accepted sample until it reaches the output register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            fill_cnt  <= '0;
        end else begin
            if (rnd_x > OMAX)      out_data <= OMAX[OUT_WIDTH-1:0];
            else if (rnd_x < OMIN) out_data <= OMIN[OUT_WIDTH-1:0];
            else                   out_data <= rnd_x[OUT_WIDTH-1:0];
            if (fill_cnt == '0) begin
                if (in_valid && tx_enable) fill_cnt <= CW'(1);
            end else if (fill_cnt != CW'(STG + 2)) begin
                fill_cnt <= fill_cnt + CW'(1);
            end
            if (fill_cnt == CW'(STG + 2)) out_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tx_cordic_upconverter.sv
// Bench for tx_cordic_upconverter: directed and random stimulus compared every clock
// against a floating-point rotate/scale model with a latency queue.
module tb_tx_cordic_upconverter;

    localparam int IN_WIDTH  = 16;
    localparam int OUT_WIDTH = 12;
    localparam int STG       = 16;
    localparam int S         = IN_WIDTH - OUT_WIDTH + 1;
    localparam real PI       = 3.14159265358979323846;
    localparam real KGAIN    = 1.6467602581;

    logic                        clock;
    logic                        reset_n;
    logic signed [31:0]          frequency;
    logic                        tx_enable;
    logic                        in_valid;
    logic signed [IN_WIDTH-1:0]  in_I;
    logic signed [IN_WIDTH-1:0]  in_Q;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic                        out_valid;

    int tests_run;
    int tests_failed;

    bit [31:0] m_phase;
    int        m_hi, m_hq;
    bit        m_started;
    int        m_accept_edge;
    int        edge_cnt;
    int        exp_q[$];
    int        last_out;

    tx_cordic_upconverter #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .STG      (STG)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .frequency(frequency),
        .tx_enable(tx_enable),
        .in_valid (in_valid),
        .in_I     (in_I),
        .in_Q     (in_Q),
        .out_data (out_data),
        .out_valid(out_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input int observed, input int expected, input int tol);
        int diff;
        tests_run++;
        diff = observed - expected;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            tests_failed++;
            $display("[TB] FAIL %s at edge %0d: observed %0d, expected %0d (tol %0d)",
                     tag, edge_cnt, observed, expected, tol);
        end
    endtask

    // Real output = K * (I cos(phi) - Q sin(phi)) / 2^S, rounded half-up and clamped to the DAC range
    function automatic int modelOut(input int hi, input int hq, input bit [31:0] ph);
        real phi, x, r;
        phi = 2.0 * PI * real'(ph) / 4294967296.0;
        x   = KGAIN * (real'(hi) * $cos(phi) - real'(hq) * $sin(phi)) / real'(1 << S);
        r   = $floor(x + 0.5);
        if (r > real'((1 << (OUT_WIDTH - 1)) - 1)) r = real'((1 << (OUT_WIDTH - 1)) - 1);
        if (r < -real'(1 << (OUT_WIDTH - 1)))      r = -real'(1 << (OUT_WIDTH - 1));
        return $rtoi(r);
    endfunction

    task automatic resetModel();
        m_phase       = '0;
        m_hi          = 0;
        m_hq          = 0;
        m_started     = 1'b0;
        m_accept_edge = 0;
        edge_cnt      = 0;
        exp_q.delete();
        for (int k = 0; k < STG + 1; k++) exp_q.push_back(0);
    endtask

    task automatic applyStimulus(input bit [31:0] freq, input bit en, input bit vld, input int i, input int q);
        int  exp_out;
        bit  exp_valid;
        bit [31:0] fv;
        bit [15:0] iv, qv;
        fv = freq;
        iv = i[15:0];
        qv = q[15:0];
        exp_q.push_back(modelOut(m_hi, m_hq, m_phase));
        frequency = fv;
        tx_enable = en;
        in_valid  = vld;
        in_I      = iv;
        in_Q      = qv;
        m_phase   = m_phase + freq;
        @(posedge clock);
        #1;
        edge_cnt++;
        if (!en) begin
            m_hi = 0;
            m_hq = 0;
        end else if (vld) begin
            m_hi = int'($signed(iv));
            m_hq = int'($signed(qv));
            if (!m_started) begin
                m_started     = 1'b1;
                m_accept_edge = edge_cnt;
            end
        end
        exp_out   = exp_q.pop_front();
        exp_valid = m_started && (edge_cnt >= m_accept_edge + STG + 2);
        last_out  = int'(out_data);
        checkOutput("out_data", int'(out_data), exp_out, 2);
        checkOutput("out_valid", int'(out_valid), int'(exp_valid), 0);
    endtask

    task automatic pulseReset();
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_data", int'(out_data), 0, 0);
        checkOutput("rst_valid", int'(out_valid), 0, 0);
        #2 reset_n = 1'b1;
        resetModel();
    endtask

    initial begin
        int sat_max, sat_min;
        bit [31:0] rfreq;
        tests_run    = 0;
        tests_failed = 0;
        last_out     = 0;
        reset_n      = 1'b0;
        frequency    = '0;
        tx_enable    = 1'b0;
        in_valid     = 1'b0;
        in_I         = '0;
        in_Q         = '0;
        resetModel();

        #22;
        checkOutput("reset_data", int'(out_data), 0, 0);
        checkOutput("reset_valid", int'(out_valid), 0, 0);
        reset_n = 1'b1;

        // Single sample at zero frequency: DC output after the fill latency
        applyStimulus(32'd0, 1'b1, 1'b1, 16384, 0);
        for (int k = 0; k < STG + 6; k++) applyStimulus(32'd0, 1'b1, 1'b0, 0, 0);
        checkOutput("dc843", int'(out_data), 843, 2);
        checkOutput("dc_valid", int'(out_valid), 1, 0);

        // Quarter-turn NCO: +843, 0, -843, 0 cycle
        for (int k = 0; k < STG + 12; k++) applyStimulus(32'h4000_0000, 1'b1, 1'b1, 16384, 0);

        // Full-scale input at 45-degree steps drives both saturation limits
        sat_max = -100000;
        sat_min = 100000;
        for (int k = 0; k < STG + 24; k++) begin
            applyStimulus(32'h2000_0000, 1'b1, 1'b1, 32767, -32767);
            if (k >= STG + 8) begin
                if (last_out > sat_max) sat_max = last_out;
                if (last_out < sat_min) sat_min = last_out;
            end
        end
        checkOutput("sat_pos", sat_max, 2047, 0);
        checkOutput("sat_neg", sat_min, -2048, 0);

        // Disabled transmitter ignores samples and the hold stays cleared on re-enable
        pulseReset();
        for (int k = 0; k < STG + 6; k++) applyStimulus(32'h1234_5678, 1'b0, k[0], 20000, -15000);
        for (int k = 0; k < STG + 6; k++) applyStimulus(32'h1234_5678, 1'b1, 1'b0, 0, 0);
        checkOutput("hold_cleared", int'(out_data), 0, 0);
        checkOutput("no_valid", int'(out_valid), 0, 0);

        // Randomized run with a mid-stream reset
        rfreq = $urandom;
        for (int n = 0; n < 4000; n++) begin
            if (n == 2000) pulseReset();
            if ((n % 250) == 0) rfreq = $urandom;
            applyStimulus(rfreq, ($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 65535)) - 32768,
                          int'($urandom_range(0, 65535)) - 32768);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
